// File: rtl/muldiv_sched.sv
// Iterative HI/LO multiply/divide unit with its own sequencing controller.
// A start in EX runs a 32-step shift-add multiply or restoring divide, then a
// single FIX cycle applies sign correction and commits HI/LO.
module muldiv_sched #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            EX_MulDivStart,
   input  logic [1:0]      EX_Op,
   input  logic [XLEN-1:0] EX_A,
   input  logic [XLEN-1:0] EX_B,
   input  logic            EX_WriteHi,
   input  logic            EX_WriteLo,
   input  logic [XLEN-1:0] EX_WriteData,
   input  logic            EX_Flush,
   input  logic            ID_ReadHiLo,
   input  logic            ID_MulDiv,
   output logic            Busy,
   output logic            Stall_Req,
   output logic [XLEN-1:0] HI,
   output logic [XLEN-1:0] LO
);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(XLEN - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d;          // |A|: multiplicand
   logic [XLEN-1:0]   b_q, b_d;          // |B|: divisor
   logic [XLEN-1:0]   raw_a_q, raw_a_d;  // unmodified A for divide-by-zero HI
   logic              neg_quo_q, neg_quo_d;
   logic              neg_rem_q, neg_rem_d;
   logic              dz_q, dz_d;
   logic [XLEN-1:0]   p_hi_q, p_hi_d;    // product high / remainder
   logic [XLEN-1:0]   p_lo_q, p_lo_d;    // multiplier+product low / quotient
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;

   logic              idle, accept, wr_ok, sgn;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic [XLEN:0]     add_sum, rem_sh, diff;
   logic              ge;
   logic [XLEN-1:0]   mul_hi, mul_lo, div_hi, div_lo;
   logic [2*XLEN-1:0] prod, prod_neg;
   logic              unused_diff_msb;

   assign idle   = (state_q == StIdle);
   assign accept = idle & EX_MulDivStart & ~EX_Flush;
   assign wr_ok  = idle & ~EX_Flush;
   assign sgn    = ~EX_Op[0];
   assign abs_a  = (sgn & EX_A[XLEN-1]) ? -EX_A : EX_A;
   assign abs_b  = (sgn & EX_B[XLEN-1]) ? -EX_B : EX_B;

   // One iteration of each datapath, computed from the current accumulator
   always_comb begin
      add_sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, a_q} : '0);
      mul_hi  = add_sum[XLEN:1];
      mul_lo  = {add_sum[0], p_lo_q[XLEN-1:1]};
      rem_sh  = {p_hi_q, p_lo_q[XLEN-1]};
      ge      = (rem_sh >= {1'b0, b_q});
      diff    = rem_sh - {1'b0, b_q};
      // remainder stays below the divisor, so the low XLEN bits always suffice
      div_hi  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      div_lo  = {p_lo_q[XLEN-2:0], ge};
      prod     = {p_hi_q, p_lo_q};
      prod_neg = -prod;
   end

   assign unused_diff_msb = diff[XLEN];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = StRun;
         StRun:   if (cnt_q == CntLast) state_d = StFix;
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      Busy      = (state_q != StIdle);
      Stall_Req = Busy & (ID_ReadHiLo | ID_MulDiv);
   end

   // Datapath next-state: operand latch, iterate, commit, mthi/mtlo
   always_comb begin
      cnt_d     = cnt_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      raw_a_d   = raw_a_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      p_hi_d    = p_hi_q;
      p_lo_d    = p_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         StIdle: begin
            if (wr_ok & EX_WriteHi) hi_d = EX_WriteData;
            if (wr_ok & EX_WriteLo) lo_d = EX_WriteData;
            if (accept) begin
               op_d      = EX_Op;
               a_d       = abs_a;
               b_d       = abs_b;
               raw_a_d   = EX_A;
               neg_quo_d = sgn & (EX_A[XLEN-1] ^ EX_B[XLEN-1]);
               neg_rem_d = sgn & EX_A[XLEN-1];
               dz_d      = (EX_B == '0);
               cnt_d     = '0;
               p_hi_d    = '0;
               p_lo_d    = EX_Op[1] ? abs_a : abs_b;
            end
         end
         StRun: begin
            p_hi_d = op_q[1] ? div_hi : mul_hi;
            p_lo_d = op_q[1] ? div_lo : mul_lo;
            if (cnt_q != CntLast) cnt_d = cnt_q + CNT_W'(1);
         end
         StFix: begin
            if (!op_q[1]) begin
               {hi_d, lo_d} = neg_quo_q ? prod_neg : prod;
            end else if (dz_q) begin
               lo_d = '1;
               hi_d = raw_a_q;
            end else begin
               lo_d = neg_quo_q ? -p_lo_q : p_lo_q;
               hi_d = neg_rem_q ? -p_hi_q : p_hi_q;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         raw_a_q   <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         p_hi_q    <= '0;
         p_lo_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         raw_a_q   <= raw_a_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         p_hi_q    <= p_hi_d;
         p_lo_q    <= p_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign HI = hi_q;
   assign LO = lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: directed cases plus random ops checked
// against an arithmetic reference model of HI/LO.
module tb_muldiv_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        EX_MulDivStart;
   logic [1:0]  EX_Op;
   logic [31:0] EX_A, EX_B;
   logic        EX_WriteHi, EX_WriteLo;
   logic [31:0] EX_WriteData;
   logic        EX_Flush;
   logic        ID_ReadHiLo, ID_MulDiv;
   logic        Busy, Stall_Req;
   logic [31:0] HI, LO;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] hi_m, lo_m;  // model copy of HI/LO

   muldiv_sched #(.XLEN(32), .CNT_W(5)) dut (
      .clk           (clk),
      .reset         (reset),
      .EX_MulDivStart(EX_MulDivStart),
      .EX_Op         (EX_Op),
      .EX_A          (EX_A),
      .EX_B          (EX_B),
      .EX_WriteHi    (EX_WriteHi),
      .EX_WriteLo    (EX_WriteLo),
      .EX_WriteData  (EX_WriteData),
      .EX_Flush      (EX_Flush),
      .ID_ReadHiLo   (ID_ReadHiLo),
      .ID_MulDiv     (ID_MulDiv),
      .Busy          (Busy),
      .Stall_Req     (Stall_Req),
      .HI            (HI),
      .LO            (LO)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   // Reference: plain arithmetic on the architectural definitions
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      logic signed [63:0] sa, sb, sp, sq, sr;
      logic [63:0] up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      hi = '0;
      lo = '0;
      case (op)
         2'd0: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
         2'd1: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
         default: begin
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else if (op == 2'd2) begin
               sq = sa / sb; sr = sa % sb;
               lo = sq[31:0]; hi = sr[31:0];
            end else begin
               lo = a / b; hi = a % b;
            end
         end
      endcase
   endfunction

   // Drive one start (optionally with mthi/mtlo) and wait for Busy to fall
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic wr_hi, input logic wr_lo, input logic [31:0] wd,
                        output int busy_n, output int stall_n,
                        output logic [31:0] hi0, output logic [31:0] lo0);
      @(negedge clk);
      EX_MulDivStart = 1'b1; EX_Op = op; EX_A = a; EX_B = b;
      EX_WriteHi = wr_hi; EX_WriteLo = wr_lo; EX_WriteData = wd;
      @(negedge clk);
      EX_MulDivStart = 1'b0; EX_WriteHi = 1'b0; EX_WriteLo = 1'b0;
      hi0 = HI; lo0 = LO;
      busy_n = 0; stall_n = 0;
      while (Busy === 1'b1 && busy_n < 100) begin
         busy_n++;
         if (Stall_Req === 1'b1) stall_n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      EX_MulDivStart = 0; EX_Op = 0; EX_A = 0; EX_B = 0;
      EX_WriteHi = 0; EX_WriteLo = 0; EX_WriteData = 0; EX_Flush = 0;
      ID_ReadHiLo = 1'b1; ID_MulDiv = 1'b1;
      #12;
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", Busy); end
      n_cmp++; if (HI !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h want 0", HI); end
      n_cmp++; if (LO !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h want 0", LO); end
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (Stall_Req !== 1'b0) begin n_err++; $display("FAIL idle_stall got %b want 0", Stall_Req); end
      ID_ReadHiLo = 1'b0; ID_MulDiv = 1'b0;
      hi_m = '0; lo_m = '0;
   endtask

   task automatic test_directed();
      logic [1:0]  top [5] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2};
      logic [31:0] ta  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
      logic [31:0] tb  [5] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] thi [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd0};
      logic [31:0] tlo [5] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'h8000_0000};
      int bn, sn;
      logic [31:0] h0, l0;
      for (int i = 0; i < 5; i++) begin
         issue(top[i], ta[i], tb[i], 1'b0, 1'b0, 32'd0, bn, sn, h0, l0);
         n_cmp++; if (bn != 33) begin n_err++; $display("FAIL dir%0d_latency got %0d want 33", i, bn); end
         n_cmp++; if (HI !== thi[i]) begin n_err++; $display("FAIL dir%0d_hi got %h want %h", i, HI, thi[i]); end
         n_cmp++; if (LO !== tlo[i]) begin n_err++; $display("FAIL dir%0d_lo got %h want %h", i, LO, tlo[i]); end
         hi_m = thi[i]; lo_m = tlo[i];
      end
   endtask

   task automatic test_stall();
      int bn, sn;
      logic [31:0] h0, l0, eh, el;
      ID_ReadHiLo = 1'b1;
      issue(2'd0, 32'h0001_2345, 32'hFFFF_0003, 1'b0, 1'b0, 32'd0, bn, sn, h0, l0);
      model(2'd0, 32'h0001_2345, 32'hFFFF_0003, eh, el);
      n_cmp++; if (sn != 33) begin n_err++; $display("FAIL stall_read_len got %0d want 33", sn); end
      n_cmp++; if (Stall_Req !== 1'b0) begin n_err++; $display("FAIL stall_after_commit got %b want 0", Stall_Req); end
      n_cmp++; if (HI !== eh) begin n_err++; $display("FAIL stall_hi got %h want %h", HI, eh); end
      ID_ReadHiLo = 1'b0; ID_MulDiv = 1'b1;
      issue(2'd3, 32'd1000, 32'd7, 1'b0, 1'b0, 32'd0, bn, sn, h0, l0);
      n_cmp++; if (sn != 33) begin n_err++; $display("FAIL stall_muldiv_len got %0d want 33", sn); end
      ID_MulDiv = 1'b0;
      model(2'd3, 32'd1000, 32'd7, hi_m, lo_m);
   endtask

   task automatic test_flush();
      @(negedge clk);
      EX_MulDivStart = 1'b1; EX_Flush = 1'b1; EX_Op = 2'd1; EX_A = 32'd9; EX_B = 32'd9;
      EX_WriteHi = 1'b1; EX_WriteLo = 1'b1; EX_WriteData = 32'hCAFE_F00D;
      @(negedge clk);
      EX_MulDivStart = 1'b0; EX_Flush = 1'b0; EX_WriteHi = 1'b0; EX_WriteLo = 1'b0;
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b want 0", Busy); end
      n_cmp++; if (HI !== hi_m) begin n_err++; $display("FAIL flush_hi got %h want %h", HI, hi_m); end
      n_cmp++; if (LO !== lo_m) begin n_err++; $display("FAIL flush_lo got %h want %h", LO, lo_m); end
   endtask

   task automatic test_mthi_mtlo();
      logic [31:0] eh, el;
      @(negedge clk); EX_WriteHi = 1'b1; EX_WriteData = 32'h1234;
      @(negedge clk); EX_WriteHi = 1'b0;
      n_cmp++; if (HI !== 32'h1234) begin n_err++; $display("FAIL mthi got %h want 00001234", HI); end
      n_cmp++; if (LO !== lo_m) begin n_err++; $display("FAIL mthi_lo_kept got %h want %h", LO, lo_m); end
      @(negedge clk); EX_WriteHi = 1'b1; EX_WriteLo = 1'b1; EX_WriteData = 32'h5555_AAAA;
      @(negedge clk); EX_WriteHi = 1'b0; EX_WriteLo = 1'b0;
      n_cmp++; if ({HI, LO} !== {2{32'h5555_AAAA}}) begin
         n_err++; $display("FAIL mthi_mtlo_both got %h_%h want 5555aaaa_5555aaaa", HI, LO);
      end
      hi_m = 32'h5555_AAAA; lo_m = 32'h5555_AAAA;
      // mtlo presented while busy must be dropped
      @(negedge clk); EX_MulDivStart = 1'b1; EX_Op = 2'd2; EX_A = 32'hFFFF_FF00; EX_B = 32'd5;
      @(negedge clk); EX_MulDivStart = 1'b0;
      repeat (4) @(negedge clk);
      EX_WriteLo = 1'b1; EX_WriteData = 32'hDEAD_BEEF;
      @(negedge clk); EX_WriteLo = 1'b0;
      n_cmp++; if (LO !== lo_m) begin n_err++; $display("FAIL mtlo_busy got %h want %h", LO, lo_m); end
      for (int i = 0; i < 100 && Busy === 1'b1; i++) @(negedge clk);
      model(2'd2, 32'hFFFF_FF00, 32'd5, eh, el);
      n_cmp++; if (LO !== el) begin n_err++; $display("FAIL mtlo_busy_commit got %h want %h", LO, el); end
      hi_m = eh; lo_m = el;
   endtask

   task automatic test_write_and_start();
      int bn, sn;
      logic [31:0] h0, l0, eh, el;
      issue(2'd1, 32'd3, 32'd4, 1'b1, 1'b0, 32'h77, bn, sn, h0, l0);
      n_cmp++; if (h0 !== 32'h77) begin n_err++; $display("FAIL wrstart_hi_write got %h want 00000077", h0); end
      n_cmp++; if (l0 !== lo_m) begin n_err++; $display("FAIL wrstart_lo_kept got %h want %h", l0, lo_m); end
      model(2'd1, 32'd3, 32'd4, eh, el);
      n_cmp++; if ({HI, LO} !== {eh, el}) begin
         n_err++; $display("FAIL wrstart_result got %h_%h want %h_%h", HI, LO, eh, el);
      end
      hi_m = eh; lo_m = el;
   endtask

   task automatic test_start_while_busy();
      int bn;
      logic [31:0] eh, el;
      @(negedge clk); EX_MulDivStart = 1'b1; EX_Op = 2'd0; EX_A = 32'd123; EX_B = 32'hFFFF_FFF6;
      @(negedge clk); EX_MulDivStart = 1'b0;
      bn = 1;
      repeat (5) begin @(negedge clk); bn++; end
      EX_MulDivStart = 1'b1; EX_Op = 2'd3; EX_A = 32'd77; EX_B = 32'd3;
      @(negedge clk); EX_MulDivStart = 1'b0; bn++;
      while (Busy === 1'b1 && bn < 100) begin @(negedge clk); bn++; end
      model(2'd0, 32'd123, 32'hFFFF_FFF6, eh, el);
      n_cmp++; if (bn != 34) begin n_err++; $display("FAIL busy_start_len got %0d want 34", bn); end
      n_cmp++; if ({HI, LO} !== {eh, el}) begin
         n_err++; $display("FAIL busy_start_result got %h_%h want %h_%h", HI, LO, eh, el);
      end
      @(negedge clk);
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL busy_start_ignored got %b want 0", Busy); end
      hi_m = eh; lo_m = el;
   endtask

   task automatic test_reset_midrun();
      int bn, sn;
      logic [31:0] h0, l0;
      @(negedge clk); EX_MulDivStart = 1'b1; EX_Op = 2'd1; EX_A = 32'd5; EX_B = 32'd6;
      @(negedge clk); EX_MulDivStart = 1'b0;
      repeat (9) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL midrun_reset_busy got %b want 0", Busy); end
      n_cmp++; if ({HI, LO} !== 64'd0) begin
         n_err++; $display("FAIL midrun_reset_hilo got %h_%h want 0_0", HI, LO);
      end
      @(negedge clk); reset = 1'b0;
      issue(2'd1, 32'd5, 32'd6, 1'b0, 1'b0, 32'd0, bn, sn, h0, l0);
      n_cmp++; if (bn != 33) begin n_err++; $display("FAIL midrun_restart_len got %0d want 33", bn); end
      n_cmp++; if ({HI, LO} !== {32'd0, 32'd30}) begin
         n_err++; $display("FAIL midrun_restart got %h_%h want 0_1e", HI, LO);
      end
      hi_m = 32'd0; lo_m = 32'd30;
   endtask

   task automatic test_random();
      int bn, sn;
      logic [31:0] h0, l0, a, b, eh, el;
      logic [1:0] op;
      for (int i = 0; i < 25; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = -32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
         issue(op, a, b, 1'b0, 1'b0, 32'd0, bn, sn, h0, l0);
         model(op, a, b, eh, el);
         n_cmp++; if (bn != 33) begin n_err++; $display("FAIL rnd%0d_latency got %0d want 33", i, bn); end
         n_cmp++; if (HI !== eh) begin
            n_err++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, op, a, b, HI, eh);
         end
         n_cmp++; if (LO !== el) begin
            n_err++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, op, a, b, LO, el);
         end
         hi_m = eh; lo_m = el;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_flush();
      test_mthi_mtlo();
      test_write_and_start();
      test_start_while_busy();
      test_reset_midrun();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
